// File: rtl/crack_sequencer_pkg.sv
// Shared architecture widths, PowerPC opcode/XO constants and field helpers for the crack sequencer.
// Instruction bits are numbered big-endian [0:31], matching the ISA manuals.
package crack_sequencer_pkg;

  localparam int PC_WIDTH      = 32;
  localparam int INSTR_WIDTH   = 32;
  localparam int UOP_IDX_WIDTH = 5;
  localparam int CNT_WIDTH     = 6;

  typedef logic [0:INSTR_WIDTH-1] instr_t;
  typedef logic [0:PC_WIDTH-1]    pc_t;
  typedef logic [CNT_WIDTH-1:0]   cnt_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_t;

  localparam logic [5:0] OP_ADDI  = 6'd14;
  localparam logic [5:0] OP_X31   = 6'd31;
  localparam logic [5:0] OP_LWZ   = 6'd32;
  localparam logic [5:0] OP_LWZU  = 6'd33;
  localparam logic [5:0] OP_LBZU  = 6'd35;
  localparam logic [5:0] OP_STW   = 6'd36;
  localparam logic [5:0] OP_STWU  = 6'd37;
  localparam logic [5:0] OP_STBU  = 6'd39;
  localparam logic [5:0] OP_LHZU  = 6'd41;
  localparam logic [5:0] OP_LHAU  = 6'd43;
  localparam logic [5:0] OP_STHU  = 6'd45;
  localparam logic [5:0] OP_LMW   = 6'd46;
  localparam logic [5:0] OP_STMW  = 6'd47;
  localparam logic [5:0] OP_DS_LD = 6'd58;
  localparam logic [5:0] OP_DS_ST = 6'd62;

  localparam logic [9:0] XO_LDUX  = 10'd53;
  localparam logic [9:0] XO_LWZUX = 10'd55;
  localparam logic [9:0] XO_LBZUX = 10'd119;
  localparam logic [9:0] XO_STDUX = 10'd181;
  localparam logic [9:0] XO_STWUX = 10'd183;
  localparam logic [9:0] XO_STBUX = 10'd247;
  localparam logic [9:0] XO_LHZUX = 10'd311;
  localparam logic [9:0] XO_LWAUX = 10'd373;
  localparam logic [9:0] XO_LHAUX = 10'd375;
  localparam logic [9:0] XO_STHUX = 10'd439;
  // Every indexed update form sits exactly 32 above its plain indexed form.
  localparam logic [9:0] XO_UPD_TO_IDX = 10'd32;
  localparam logic [8:0] XO_ADD        = 9'd266;

  function automatic logic [5:0]  f_opcd(input instr_t i); return i[0:5];   endfunction
  function automatic logic [4:0]  f_rt  (input instr_t i); return i[6:10];  endfunction
  function automatic logic [4:0]  f_ra  (input instr_t i); return i[11:15]; endfunction
  function automatic logic [4:0]  f_rb  (input instr_t i); return i[16:20]; endfunction
  function automatic logic [15:0] f_d   (input instr_t i); return i[16:31]; endfunction
  function automatic logic [9:0]  f_xo  (input instr_t i); return i[21:30]; endfunction
  function automatic logic [1:0]  f_dsxo(input instr_t i); return i[30:31]; endfunction

  function automatic logic is_ds_form(input instr_t i);
    return (f_opcd(i) == OP_DS_LD) || (f_opcd(i) == OP_DS_ST);
  endfunction

  function automatic logic is_d_update(input instr_t i);
    case (f_opcd(i))
      OP_LWZU, OP_LBZU, OP_LHZU, OP_LHAU,
      OP_STWU, OP_STBU, OP_STHU: return 1'b1;
      OP_DS_LD, OP_DS_ST:        return f_dsxo(i) == 2'b01;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic is_x_update(input instr_t i);
    if (f_opcd(i) != OP_X31) return 1'b0;
    case (f_xo(i))
      XO_LDUX, XO_LWZUX, XO_LBZUX, XO_STDUX, XO_STWUX,
      XO_STBUX, XO_LHZUX, XO_LWAUX, XO_LHAUX, XO_STHUX: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic is_multi(input instr_t i);
    return (f_opcd(i) == OP_LMW) || (f_opcd(i) == OP_STMW);
  endfunction

  function automatic cnt_t crack_cnt(input instr_t i);
    if (is_d_update(i) || is_x_update(i)) return cnt_t'(2);
    if (is_multi(i))                      return 6'd32 - {1'b0, f_rt(i)};
    return cnt_t'(1);
  endfunction

endpackage

// File: rtl/crack_sequencer_decode.sv
// Combinational cracker: micro-op count and encoding of micro-op idx for one instruction.
module crack_decode
  import crack_sequencer_pkg::*;
(
  input  logic [0:INSTR_WIDTH-1] instr,
  input  logic [CNT_WIDTH-1:0]   idx,
  output logic [CNT_WIDTH-1:0]   cnt,
  output logic [0:INSTR_WIDTH-1] uop
);

  logic        first;
  logic [15:0] upd_disp;

  assign first = (idx == 6'd0);
  assign cnt   = crack_cnt(instr);
  // DS-form displacements carry two implied zero bits where the sub-opcode lives.
  assign upd_disp = is_ds_form(instr) ? {f_d(instr)[15:2], 2'b00} : f_d(instr);

  always_comb begin
    uop = instr;
    if (is_d_update(instr)) begin
      if (!first)
        uop = {OP_ADDI, f_ra(instr), f_ra(instr), upd_disp};
      else if (is_ds_form(instr))
        uop = {instr[0:29], 2'b00};
      else
        uop = {f_opcd(instr) - 6'd1, instr[6:31]};
    end else if (is_x_update(instr)) begin
      if (first)
        uop = {instr[0:20], f_xo(instr) - XO_UPD_TO_IDX, 1'b0};
      else
        uop = {OP_X31, f_ra(instr), f_ra(instr), f_rb(instr), 1'b0, XO_ADD, 1'b0};
    end else if (is_multi(instr)) begin
      uop = {(f_opcd(instr) == OP_LMW) ? OP_LWZ : OP_STW,
             f_rt(instr) + idx[4:0],
             f_ra(instr),
             f_d(instr) + {8'd0, idx, 2'b00}};
    end
  end

endmodule

// File: rtl/crack_sequencer.sv
// One-entry instruction buffer that issues cracked micro-ops one per cycle between fetch and decode.
// Micro-op 0 appears the cycle after acceptance; flush drops the held instruction.
module crack_sequencer
  import crack_sequencer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [0:PC_WIDTH-1]      if_pc,
  input  logic [0:INSTR_WIDTH-1]   if_instr,
  output logic                     uop_valid,
  input  logic                     uop_ready,
  output logic [0:PC_WIDTH-1]      uop_pc,
  output logic [0:INSTR_WIDTH-1]   uop_instr,
  output logic [UOP_IDX_WIDTH-1:0] uop_idx,
  output logic                     uop_last
);

  seq_state_t state, state_next;
  logic       held_v;
  pc_t        held_pc;
  instr_t     held_instr;
  cnt_t       idx, idx_next, cnt, dec_cnt;
  logic       is_last, uop_fire, if_fire, load;

  assign held_v   = (state == ST_ISSUE);
  assign is_last  = held_v && (idx == cnt - 6'd1);
  assign uop_fire = held_v && uop_ready;
  assign if_ready = !flush && (!held_v || (uop_fire && is_last));
  assign if_fire  = if_valid && if_ready;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
      idx_next   = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (if_fire) begin
            load       = 1'b1;
            state_next = ST_ISSUE;
            idx_next   = '0;
          end
        end
        ST_ISSUE: begin
          if (uop_fire) begin
            if (!is_last) begin
              idx_next = idx + 6'd1;
            end else begin
              idx_next = '0;
              if (if_fire) load = 1'b1;
              else         state_next = ST_EMPTY;
            end
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_pc    <= '0;
      held_instr <= '0;
      cnt        <= '0;
    end else if (load) begin
      held_pc    <= if_pc;
      held_instr <= if_instr;
      cnt        <= crack_cnt(if_instr);
    end
  end

  crack_decode u_decode (
    .instr (held_instr),
    .idx   (idx),
    .cnt   (dec_cnt),
    .uop   (uop_instr)
  );

  // The count latched at load must always agree with the decoder's view of the held instruction.
  a_cnt_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    held_v |-> (cnt == dec_cnt));

  assign uop_valid = held_v;
  assign uop_pc    = held_pc;
  assign uop_idx   = idx[UOP_IDX_WIDTH-1:0];
  assign uop_last  = is_last;

endmodule

// File: tb/tb_crack_sequencer.sv
// Directed bench for crack_sequencer: cracking patterns, back-pressure, flush and reset recovery.
module tb_crack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, flush, if_valid, if_ready, uop_valid, uop_ready, uop_last;
  logic [0:31] if_pc, if_instr, uop_pc, uop_instr;
  logic [4:0]  uop_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  crack_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .uop_valid (uop_valid),
    .uop_ready (uop_ready),
    .uop_pc    (uop_pc),
    .uop_instr (uop_instr),
    .uop_idx   (uop_idx),
    .uop_last  (uop_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(uop_valid), 32'd0);
    chk({tag, "_pc"}, uop_pc, 32'd0);
    chk({tag, "_instr"}, uop_instr, 32'd0);
    chk({tag, "_idx"}, 32'(uop_idx), 32'd0);
    chk({tag, "_last"}, 32'(uop_last), 32'd0);
    chk({tag, "_if_ready"}, 32'(if_ready), 32'd1);
  endtask

  // Present one instruction for a single cycle; the buffer must be able to take it.
  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
    #1;
    chk("issue_if_ready", 32'(if_ready), 32'd1);
    @(negedge clk);
    if_valid = 1'b0;
    #1;
  endtask

  task automatic expect_uop(input string tag, input logic [31:0] instr, input int idx,
                            input logic last, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(uop_valid), 32'd1);
    chk({tag, "_instr"}, uop_instr, instr);
    chk({tag, "_idx"}, 32'(uop_idx), 32'(idx));
    chk({tag, "_last"}, 32'(uop_last), 32'(last));
    chk({tag, "_pc"}, uop_pc, pc);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pt [4];
    pt[0] = 32'h38210001;
    pt[1] = 32'h7C632378;
    pt[2] = 32'h60000000;
    pt[3] = 32'h4E800020;

    rst_n = 1'b1; flush = 1'b0; if_valid = 1'b0; uop_ready = 1'b1;
    if_pc = '0; if_instr = '0;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // D-form update load
    issue(32'h100, 32'h84640008);
    chk("lwzu_if_ready_mid", 32'(if_ready), 32'd0);
    expect_uop("lwzu0", 32'h80640008, 0, 1'b0, 32'h100);
    expect_uop("lwzu1", 32'h38840008, 1, 1'b1, 32'h100);
    chk("lwzu_drained", 32'(uop_valid), 32'd0);

    // X-form update load
    issue(32'h104, 32'h7C64286E);
    expect_uop("lwzux0", 32'h7C64282E, 0, 1'b0, 32'h104);
    expect_uop("lwzux1", 32'h7C842A14, 1, 1'b1, 32'h104);

    // lmw with three stalled cycles on micro-op 1
    issue(32'h108, 32'hBBA10000);
    expect_uop("lmw0", 32'h83A10000, 0, 1'b0, 32'h108);
    uop_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_instr", uop_instr, 32'h83C10004);
      chk("stall_idx", 32'(uop_idx), 32'd1);
      chk("stall_valid", 32'(uop_valid), 32'd1);
      chk("stall_if_ready", 32'(if_ready), 32'd0);
      @(negedge clk);
    end
    uop_ready = 1'b1;
    #1;
    expect_uop("lmw1", 32'h83C10004, 1, 1'b0, 32'h108);
    expect_uop("lmw2", 32'h83E10008, 2, 1'b1, 32'h108);

    // stmw of one register, then lmw whose displacement wraps
    issue(32'h10C, 32'hBFE1FFFC);
    expect_uop("stmw0", 32'h93E1FFFC, 0, 1'b1, 32'h10C);
    issue(32'h110, 32'hBBC1FFFC);
    expect_uop("lmwwrap0", 32'h83C1FFFC, 0, 1'b0, 32'h110);
    expect_uop("lmwwrap1", 32'h83E10000, 1, 1'b1, 32'h110);

    // Back-to-back passthrough with fetch always valid
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        if_valid = 1'b1;
        if_pc    = 32'h200 + 32'(4 * i);
        if_instr = pt[i];
      end else begin
        if_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        chk("b2b_valid", 32'(uop_valid), 32'd1);
        chk("b2b_instr", uop_instr, pt[i-1]);
        chk("b2b_idx", 32'(uop_idx), 32'd0);
        chk("b2b_last", 32'(uop_last), 32'd1);
        chk("b2b_pc", uop_pc, 32'h200 + 32'(4 * (i - 1)));
      end
      if (i < 4) chk("b2b_if_ready", 32'(if_ready), 32'd1);
      @(negedge clk);
    end
    #1;
    chk("b2b_drained", 32'(uop_valid), 32'd0);

    // Flush during idx 1 of a three-micro-op lmw
    issue(32'h300, 32'hBBA10000);
    expect_uop("fl_lmw0", 32'h83A10000, 0, 1'b0, 32'h300);
    flush = 1'b1;
    #1;
    chk("flush_if_ready", 32'(if_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(uop_valid), 32'd0);
    chk("flush_last", 32'(uop_last), 32'd0);
    chk("flush_idx", 32'(uop_idx), 32'd0);
    issue(32'h304, 32'h84640008);
    expect_uop("fl_next0", 32'h80640008, 0, 1'b0, 32'h304);
    expect_uop("fl_next1", 32'h38840008, 1, 1'b1, 32'h304);

    // Reset during idx 1 of a three-micro-op lmw
    issue(32'h400, 32'hBBA10000);
    expect_uop("rs_lmw0", 32'h83A10000, 0, 1'b0, 32'h400);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    #1;
    chk_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    issue(32'h500, 32'h60000000);
    expect_uop("rs_next", 32'h60000000, 0, 1'b1, 32'h500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
